// File: rtl/rotor_return.sv
// rotor_return: return path (reflector -> keyboard) of one Enigma rotor.
// Maps a one-hot letter back through the inverse rotor wiring at the current
// rotor position, registered with one cycle of latency. Also owns the rotor
// position register, stepping and the notch carry to the next rotor.
// Optional build macro: ROTOR_ONEHOT_CHECK_EN adds a sticky `err` output and
// drops letters that are not exactly one-hot.
module rotor_return #(
  parameter int unsigned NOTCH     = 16,
  parameter int unsigned RESET_POS = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [4:0]  load_pos,
  input  logic        step,
  input  logic        in_valid,
  input  logic [25:0] in,
  output logic        out_valid,
  output logic [25:0] out,
  output logic [4:0]  position,
  output logic        carry_out
`ifdef ROTOR_ONEHOT_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam logic [4:0] NOTCH_POS = 5'(NOTCH);
  localparam logic [4:0] INIT_POS  = 5'(RESET_POS);

  // Fixed wiring f; it is an involution, so the same table serves both ways.
  function automatic logic [4:0] wire_f(input logic [4:0] k);
    logic [4:0] r;
    case (k)
      5'd0:    r = 5'd17;
      5'd17:   r = 5'd0;
      5'd1:    r = 5'd20;
      5'd20:   r = 5'd1;
      5'd2:    r = 5'd12;
      5'd12:   r = 5'd2;
      5'd3:    r = 5'd23;
      5'd23:   r = 5'd3;
      5'd4:    r = 5'd9;
      5'd9:    r = 5'd4;
      5'd5:    r = 5'd10;
      5'd10:   r = 5'd5;
      5'd6:    r = 5'd15;
      5'd15:   r = 5'd6;
      5'd7:    r = 5'd18;
      5'd18:   r = 5'd7;
      5'd8:    r = 5'd25;
      5'd25:   r = 5'd8;
      5'd11:   r = 5'd24;
      5'd24:   r = 5'd11;
      5'd13:   r = 5'd16;
      5'd16:   r = 5'd13;
      5'd14:   r = 5'd21;
      5'd21:   r = 5'd14;
      5'd19:   r = 5'd22;
      5'd22:   r = 5'd19;
      default: r = k;
    endcase
    return r;
  endfunction

  // Operands are always 0..25, so a single conditional correction suffices.
  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 6'd26) sum = sum - 6'd26;
    return 5'(sum);
  endfunction

  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] diff;
    diff = {1'b0, a} + 6'd26 - {1'b0, b};
    if (diff >= 6'd26) diff = diff - 6'd26;
    return 5'(diff);
  endfunction

  logic [25:0] enc;
  logic        in_ok;

  // Transform: out[m] = in[(f((m - s) mod 26) + s) mod 26] at position s.
  always_comb begin
    logic [4:0] rel;
    logic [4:0] src;
    enc = '0;
    rel = '0;
    src = '0;
    for (int m = 0; m < 26; m++) begin
      rel    = sub26(5'(m), position);
      src    = add26(wire_f(rel), position);
      enc[m] = in[src];
    end
  end

  // Letter acceptance: everything is accepted unless the one-hot check is built in.
  always_comb begin
`ifdef ROTOR_ONEHOT_CHECK_EN
    in_ok = $onehot(in);
`else
    in_ok = 1'b1;
`endif
  end

  // Position register with load > step > hold priority and the notch carry pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      position  <= INIT_POS;
      carry_out <= 1'b0;
    end else if (load) begin
      position  <= (load_pos > 5'd25) ? 5'd0 : load_pos;
      carry_out <= 1'b0;
    end else if (step) begin
      position  <= (position == 5'd25) ? 5'd0 : position + 5'd1;
      carry_out <= (position == NOTCH_POS);
    end else begin
      carry_out <= 1'b0;
    end
  end

  // Output register; encodes with the position held in the same cycle as in_valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
`ifdef ROTOR_ONEHOT_CHECK_EN
      err       <= 1'b0;
`endif
    end else if (in_valid && !in_ok) begin
      out       <= '0;
      out_valid <= 1'b0;
`ifdef ROTOR_ONEHOT_CHECK_EN
      err       <= 1'b1;
`endif
    end else begin
      out       <= in_valid ? enc : 26'd0;
      out_valid <= in_valid;
    end
  end

endmodule
